// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter in front of one shared shift-add multiplier. It grants one requester,
// captures that requester's operands, runs N add/shift steps, and returns the product with the requester id.
module mult_share_arbiter #(
   parameter int N    = 8,
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic                 clk,
   input  logic                 stop_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*N-1:0]    a_bus,
   input  logic [NREQ*N-1:0]    b_bus,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic                 res_valid,
   output logic [ID_W-1:0]      res_id,
   output logic [2*N-1:0]       product
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t              state_reg, state_next;
   logic [ID_W-1:0]     ptr_reg, ptr_next;
   logic [2*N-1:0]      a_reg, a_next;
   logic [N-1:0]        b_reg, b_next;
   logic [ID_W-1:0]     id_reg, id_next;
   logic [2*N-1:0]      acc_reg, acc_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [NREQ-1:0]     gnt_reg, gnt_next;
   logic                busy_reg, busy_next;
   logic                res_valid_reg, res_valid_next;
   logic [ID_W-1:0]     res_id_reg, res_id_next;
   logic [2*N-1:0]      product_reg, product_next;

   // Candidate index for each scan offset from the round-robin pointer
   logic [ID_W:0]       cand_sum [NREQ];
   logic [ID_W-1:0]     cand_idx [NREQ];
   logic                found;
   logic [ID_W-1:0]     win_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         assign cand_sum[gi] = {1'b0, ptr_reg} + (ID_W+1)'(gi);
         assign cand_idx[gi] = (cand_sum[gi] >= (ID_W+1)'(NREQ))
                             ? ID_W'(cand_sum[gi] - (ID_W+1)'(NREQ))
                             : ID_W'(cand_sum[gi]);
      end
   endgenerate

   // Descending scan so the smallest offset from ptr wins
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[cand_idx[k]]) begin
            found   = 1'b1;
            win_idx = cand_idx[k];
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      a_next         = a_reg;
      b_next         = b_reg;
      id_next        = id_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      gnt_next       = '0;
      busy_next      = busy_reg;
      res_valid_next = 1'b0;
      res_id_next    = res_id_reg;
      product_next   = product_reg;
      case (state_reg)
         IDLE: begin
            if (found) begin
               a_next            = {{N{1'b0}}, a_bus[int'(win_idx)*N +: N]};
               b_next            = b_bus[int'(win_idx)*N +: N];
               id_next           = win_idx;
               acc_next          = '0;
               cnt_next          = '0;
               gnt_next[win_idx] = 1'b1;
               busy_next         = 1'b1;
               state_next        = MUL;
               ptr_next          = (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end
         end
         MUL: begin
            // Every bit takes one cycle, including zero bits, so latency is fixed
            if (b_reg[cnt_reg]) begin
               acc_next = acc_reg + (a_reg << cnt_reg);
            end
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(N - 1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            product_next   = acc_reg;
            res_id_next    = id_reg;
            res_valid_next = 1'b1;
            busy_next      = 1'b0;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge stop_n) begin
      if (!stop_n) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         id_reg        <= '0;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         gnt_reg       <= '0;
         busy_reg      <= 1'b0;
         res_valid_reg <= 1'b0;
         res_id_reg    <= '0;
         product_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         id_reg        <= id_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         gnt_reg       <= gnt_next;
         busy_reg      <= busy_next;
         res_valid_reg <= res_valid_next;
         res_id_reg    <= res_id_next;
         product_reg   <= product_next;
      end
   end

   assign gnt       = gnt_reg;
   assign busy      = busy_reg;
   assign res_valid = res_valid_reg;
   assign res_id    = res_id_reg;
   assign product   = product_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: a cycle-timeline reference model is compared on every cycle,
// and directed scenarios check the result ids, products and latencies against hand-computed values.
module tb_mult_share_arbiter;

   localparam int N    = 8;
   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic                clk;
   logic                stop_n;
   logic [NREQ-1:0]     req;
   logic [NREQ*N-1:0]   a_bus;
   logic [NREQ*N-1:0]   b_bus;
   logic [NREQ-1:0]     gnt;
   logic                busy;
   logic                res_valid;
   logic [ID_W-1:0]     res_id;
   logic [2*N-1:0]      product;

   mult_share_arbiter #(.N(N), .NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .stop_n    (stop_n),
      .req       (req),
      .a_bus     (a_bus),
      .b_bus     (b_bus),
      .gnt       (gnt),
      .busy      (busy),
      .res_valid (res_valid),
      .res_id    (res_id),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int errs  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: time since the grant decides every output; the product comes from '*'
   bit              m_act      = 1'b0;
   int              m_t        = 0;
   int              m_ptr      = 0;
   int              m_id       = 0;
   int              m_w        = -1;
   bit              m_idle     = 1'b1;
   logic [2*N-1:0]  m_prod     = '0;
   logic [2*N-1:0]  m_out_prod = '0;
   int              m_out_id   = 0;

   always @(posedge clk or negedge stop_n) begin
      if (!stop_n) begin
         m_act = 1'b0; m_t = 0; m_ptr = 0; m_id = 0;
         m_prod = '0; m_out_prod = '0; m_out_id = 0;
      end else begin
         m_idle = !m_act || (m_t == N + 1);
         m_w    = -1;
         if (m_idle) begin
            for (int k = 0; k < NREQ; k++) begin
               if (m_w < 0 && req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
            end
         end
         if (m_w >= 0) begin
            m_act  = 1'b1;
            m_t    = 0;
            m_id   = m_w;
            m_prod = (2*N)'(a_bus[m_w*N +: N]) * (2*N)'(b_bus[m_w*N +: N]);
            m_ptr  = (m_w + 1) % NREQ;
         end else if (m_act) begin
            if (m_t == N + 1) begin
               m_act = 1'b0;
            end else begin
               m_t++;
               if (m_t == N + 1) begin
                  m_out_prod = m_prod;
                  m_out_id   = m_id;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [NREQ-1:0] e_gnt;
      e_gnt = '0;
      if (m_act && m_t == 0) e_gnt[m_id] = 1'b1;
      chk("cyc_gnt",       32'(gnt),       32'(e_gnt));
      chk("cyc_busy",      32'(busy),      32'(m_act && m_t <= N));
      chk("cyc_res_valid", 32'(res_valid), 32'(m_act && m_t == N + 1));
      chk("cyc_res_id",    32'(res_id),    32'(m_out_id));
      chk("cyc_product",   32'(product),   32'(m_out_prod));
   end

   // Transaction log taken shortly after each rising edge
   int cyc = 0;
   int gnt_cyc = 0;
   int gnt_cnt = 0;
   int res_cnt = 0;
   int gnt_q[$];
   int res_id_q[$];
   int res_p_q[$];
   int res_lat_q[$];

   always @(posedge clk) begin
      #1;
      cyc++;
      if (gnt != '0) begin
         for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_q.push_back(i);
         gnt_cnt++;
         gnt_cyc = cyc;
      end
      if (res_valid) begin
         res_id_q.push_back(int'(res_id));
         res_p_q.push_back(int'(product));
         res_lat_q.push_back(cyc - gnt_cyc);
         res_cnt++;
         $display("[TB] result id=%0d product=%0d latency=%0d", res_id, product, cyc - gnt_cyc);
      end
   end

   logic [NREQ-1:0] hold = '0;

   task automatic tick();
      @(negedge clk);
      req = req & ~(gnt & ~hold);
   endtask

   task automatic set_lane(input int i, input int a, input int b);
      a_bus[i*N +: N] = N'(a);
      b_bus[i*N +: N] = N'(b);
   endtask

   task automatic wait_grants(input int total);
      int n = 0;
      while (gnt_cnt < total && n < 200) begin tick(); n++; end
      if (gnt_cnt < total) chk("grant_timeout", 32'(gnt_cnt), 32'(total));
   endtask

   task automatic wait_results(input int total);
      int n = 0;
      while (res_cnt < total && n < 200) begin tick(); n++; end
      if (res_cnt < total) chk("result_timeout", 32'(res_cnt), 32'(total));
      repeat (2) tick();
   endtask

   task automatic expect_grant(input string nm, input int id);
      if (gnt_q.size() == 0) chk({nm, "_missing"}, 32'(0), 32'(1));
      else chk(nm, 32'(gnt_q.pop_front()), 32'(id));
   endtask

   task automatic expect_result(input string nm, input int id, input int p, input bit chk_lat);
      if (res_id_q.size() == 0) begin
         chk({nm, "_missing"}, 32'(0), 32'(1));
      end else begin
         chk({nm, "_id"},      32'(res_id_q.pop_front()), 32'(id));
         chk({nm, "_product"}, 32'(res_p_q.pop_front()),  32'(p));
         if (chk_lat) chk({nm, "_latency"}, 32'(res_lat_q.pop_front()), 32'(N + 1));
         else void'(res_lat_q.pop_front());
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 stop_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 stop_n = 1'b1;
   endtask

   initial begin
      stop_n = 1'b1;
      req    = '0;
      a_bus  = '0;
      b_bus  = '0;
      #1 stop_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_gnt",     32'(gnt),       32'(0));
      chk("reset_busy",    32'(busy),      32'(0));
      chk("reset_valid",   32'(res_valid), 32'(0));
      chk("reset_product", 32'(product),   32'(0));
      #2 stop_n = 1'b1;

      // Single lane 0: 13*11
      set_lane(0, 13, 11);
      req = 4'b0001;
      wait_grants(1);
      wait_results(1);
      expect_grant("t1_gnt", 0);
      expect_result("t1", 0, 143, 1'b1);

      // All four at once from ptr=0
      do_reset();
      set_lane(0, 3, 5); set_lane(1, 7, 9); set_lane(2, 100, 2); set_lane(3, 255, 1);
      req = 4'b1111;
      wait_grants(5);
      wait_results(5);
      expect_grant("t2_gnt0", 0); expect_grant("t2_gnt1", 1);
      expect_grant("t2_gnt2", 2); expect_grant("t2_gnt3", 3);
      expect_result("t2_r0", 0, 15, 1'b1);  expect_result("t2_r1", 1, 63, 1'b1);
      expect_result("t2_r2", 2, 200, 1'b1); expect_result("t2_r3", 3, 255, 1'b1);

      // Lanes 0 and 2 held: must alternate
      hold = 4'b0101;
      req  = 4'b0101;
      wait_grants(9);
      hold = '0;
      req  = '0;
      wait_results(9);
      expect_grant("t3_gnt0", 0); expect_grant("t3_gnt1", 2);
      expect_grant("t3_gnt2", 0); expect_grant("t3_gnt3", 2);
      expect_result("t3_r0", 0, 15, 1'b1);  expect_result("t3_r1", 2, 200, 1'b1);
      expect_result("t3_r2", 0, 15, 1'b1);  expect_result("t3_r3", 2, 200, 1'b1);

      // Extremes: 255*255 and B=0 (ptr=3, so lane 0 then lane 1)
      set_lane(0, 255, 255); set_lane(1, 200, 0);
      req = 4'b0011;
      wait_grants(11);
      wait_results(11);
      expect_grant("t4_gnt0", 0); expect_grant("t4_gnt1", 1);
      expect_result("t4_max",  0, 65025, 1'b1);
      expect_result("t4_zero", 1, 0, 1'b1);

      // Reset three cycles into a multiply: aborted, then ptr restarts at 0
      set_lane(1, 6, 7); set_lane(2, 12, 12);
      req = 4'b0010;
      wait_grants(12);
      repeat (3) tick();
      #2 stop_n = 1'b0;
      #1;
      chk("t5_abort_gnt",     32'(gnt),       32'(0));
      chk("t5_abort_busy",    32'(busy),      32'(0));
      chk("t5_abort_valid",   32'(res_valid), 32'(0));
      chk("t5_abort_product", 32'(product),   32'(0));
      req = 4'b0110;
      repeat (2) @(negedge clk);
      #2 stop_n = 1'b1;
      wait_results(13);
      chk("t5_no_stale_result", 32'(res_cnt), 32'(13));
      expect_grant("t5_gnt_aborted", 1);
      expect_grant("t5_gnt0", 1); expect_grant("t5_gnt1", 2);
      expect_result("t5_r0", 1, 42, 1'b1);
      expect_result("t5_r1", 2, 144, 1'b1);

      // Operand change right after grant must not affect the product
      set_lane(1, 9, 10);
      req = 4'b0010;
      wait_grants(15);
      set_lane(1, 99, 99);
      wait_results(14);
      expect_grant("t6_gnt", 1);
      expect_result("t6", 1, 90, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
